dropout_mask_gen: RTL and testbench

DROPOUT_MASK_GEN -- requirements
Module: dropout_mask_gen

---
 rtl/dropout_mask_gen.sv | 108 ++++++++++
 tb/tb_dropout_mask_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dropout_mask_gen.sv
// Dropout mask generator: a 32-bit Galois LFSR yields one random value per accepted
// mask bit, compared against a threshold, with saturating accept/drop statistics.
module dropout_mask_gen #(
   parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [31:0]      seed,
   input  logic [31:0]      threshold,
   input  logic             clear_counts,
   input  logic             mask_ready,
   output logic             mask_valid,
   output logic             mask_drop,
   output logic [31:0]      mask_rnd,
   output logic [CNT_W-1:0] mask_count,
   output logic [CNT_W-1:0] drop_count
);

   localparam int unsigned LFSR_W   = 32;
   localparam logic [LFSR_W-1:0] POLY     = 32'h8020_0003;
   localparam logic [LFSR_W-1:0] RST_SEED = (SEED_DEFAULT == 32'd0) ? 32'd1 : SEED_DEFAULT;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [LFSR_W-1:0]   mask_rnd_q, mask_rnd_d;
   logic                mask_drop_q, mask_drop_d;
   logic [CNT_W-1:0]    mask_count_q, mask_count_d;
   logic [CNT_W-1:0]    drop_count_q, drop_count_d;

   logic [LFSR_W-1:0]   lfsr_next;
   logic                advance;
   logic                accept;

   always_comb begin
      lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? POLY : '0);
      advance   = enable && !seed_load && ((state_q == IDLE) || mask_ready);
      accept    = (state_q == ACTIVE) && mask_ready;
   end

   // Generator: seed load beats everything; a stalled bit holds until accepted.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      mask_rnd_d  = mask_rnd_q;
      mask_drop_d = mask_drop_q;
      if (seed_load) begin
         lfsr_d  = (seed == 32'd0) ? 32'd1 : seed;
         state_d = IDLE;
      end else if (advance) begin
         lfsr_d      = lfsr_next;
         mask_rnd_d  = lfsr_next;
         mask_drop_d = (lfsr_next < threshold);
         state_d     = ACTIVE;
      end else if (accept) begin
         state_d = IDLE;
      end
   end

   // Statistics: clear wins over an increment; both counters stick at all-ones.
   always_comb begin
      mask_count_d = mask_count_q;
      drop_count_d = drop_count_q;
      if (clear_counts) begin
         mask_count_d = '0;
         drop_count_d = '0;
      end else if (accept) begin
         if (mask_count_q != '1) begin
            mask_count_d = mask_count_q + CNT_W'(1);
         end
         if (mask_drop_q && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         lfsr_q       <= RST_SEED;
         mask_rnd_q   <= '0;
         mask_drop_q  <= 1'b0;
         mask_count_q <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         mask_rnd_q   <= mask_rnd_d;
         mask_drop_q  <= mask_drop_d;
         mask_count_q <= mask_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign mask_valid = (state_q == ACTIVE);
   assign mask_drop  = mask_drop_q;
   assign mask_rnd   = mask_rnd_q;
   assign mask_count = mask_count_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Scoreboard bench for dropout_mask_gen: stimulus queues hand-computed mask bits,
// a negedge monitor pops one per accepted bit; direct checks cover stalls, counters, reset.
module tb_dropout_mask_gen;

   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic [31:0] rnd;
      logic        drop;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             seed_load;
   logic [31:0]      seed;
   logic [31:0]      threshold;
   logic             clear_counts;
   logic             mask_ready;
   logic             mask_valid;
   logic             mask_drop;
   logic [31:0]      mask_rnd;
   logic [CNT_W-1:0] mask_count;
   logic [CNT_W-1:0] drop_count;

   exp_t sb_q[$];
   logic sb_en;
   int   total;
   int   bad;

   dropout_mask_gen #(
      .SEED_DEFAULT (32'h0000_0001),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .seed_load    (seed_load),
      .seed         (seed),
      .threshold    (threshold),
      .clear_counts (clear_counts),
      .mask_ready   (mask_ready),
      .mask_valid   (mask_valid),
      .mask_drop    (mask_drop),
      .mask_rnd     (mask_rnd),
      .mask_count   (mask_count),
      .drop_count   (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic [31:0] s);
      seed_load    = 1'b1;
      seed         = s;
      clear_counts = 1'b1;
      enable       = 1'b0;
      mask_ready   = 1'b0;
      tick();
      seed_load    = 1'b0;
      clear_counts = 1'b0;
   endtask

   task automatic push(input logic [31:0] rnd, input logic drop);
      exp_t e;
      e.rnd  = rnd;
      e.drop = drop;
      sb_q.push_back(e);
   endtask

   // Two-bit stream with ready held high: advance, accept+advance, accept->IDLE.
   task automatic stream_two(input logic [31:0] thr);
      threshold  = thr;
      enable     = 1'b1;
      mask_ready = 1'b1;
      tick();
      tick();
      enable = 1'b0;
      tick();
   endtask

   task automatic check_counts(input string name, input logic [CNT_W-1:0] mc,
                               input logic [CNT_W-1:0] dc);
      check({name, ".mask_count"}, 32'(mask_count), 32'(mc));
      check({name, ".drop_count"}, 32'(drop_count), 32'(dc));
   endtask

   // Monitor: every accept edge must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && sb_en && mask_valid && mask_ready) begin
         if (sb_q.size() == 0) begin
            check("sb.unexpected_accept", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb.mask_rnd", mask_rnd, e.rnd);
            check("sb.mask_drop", 32'(mask_drop), 32'(e.drop));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      total        = 0;
      bad          = 0;
      sb_en        = 1'b1;
      reset        = 1'b1;
      enable       = 1'b0;
      seed_load    = 1'b0;
      seed         = 32'd0;
      threshold    = 32'd0;
      clear_counts = 1'b0;
      mask_ready   = 1'b0;
      #1;
      check("rst.mask_valid", 32'(mask_valid), 32'd0);
      check("rst.mask_rnd", mask_rnd, 32'd0);
      check("rst.mask_drop", 32'(mask_drop), 32'd0);
      check_counts("rst", '0, '0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset seed is 1: first values 8020_0003, C030_0002, neither below 8000_0000.
      push(32'h8020_0003, 1'b0);
      push(32'hC030_0002, 1'b0);
      stream_two(32'h8000_0000);
      check("a.idle", 32'(mask_valid), 32'd0);
      check_counts("a", 16'd2, 16'd0);

      restart(32'h0000_0001);
      push(32'h8020_0003, 1'b1);
      push(32'hC030_0002, 1'b0);
      stream_two(32'hC000_0000);
      check_counts("b", 16'd2, 16'd1);

      // Stall: value and flag hold while threshold and enable wiggle.
      restart(32'h0000_0001);
      threshold  = 32'h8000_0000;
      enable     = 1'b1;
      mask_ready = 1'b0;
      push(32'h8020_0003, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         threshold = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
         enable    = (i != 3);
         tick();
         check("stall.valid", 32'(mask_valid), 32'd1);
         check("stall.rnd", mask_rnd, 32'h8020_0003);
         check("stall.drop", 32'(mask_drop), 32'd0);
         check_counts("stall", '0, '0);
      end
      enable     = 1'b0;
      mask_ready = 1'b1;
      tick();
      check_counts("stall.after", 16'd1, 16'd0);

      // Seed load of 0 while ACTIVE with an accept in the same cycle.
      restart(32'h0000_0001);
      threshold  = 32'h0000_0000;
      enable     = 1'b1;
      mask_ready = 1'b1;
      push(32'h8020_0003, 1'b0);
      tick();
      seed_load = 1'b1;
      seed      = 32'h0000_0000;
      tick();
      seed_load = 1'b0;
      check("seed0.valid", 32'(mask_valid), 32'd0);
      check_counts("seed0.same_cycle", 16'd1, 16'd0);
      push(32'h8020_0003, 1'b0);
      tick();
      enable = 1'b0;
      tick();
      check_counts("seed0", 16'd2, 16'd0);

      // Threshold all-ones: only an all-ones value passes. FFBF_FFF9 steps to FFFF_FFFF.
      restart(32'hFFBF_FFF9);
      push(32'hFFFF_FFFF, 1'b0);
      push(32'hFFDF_FFFC, 1'b1);
      stream_two(32'hFFFF_FFFF);
      check_counts("thr_max", 16'd2, 16'd1);

      // Saturation, then clear coinciding with an accept.
      restart(32'h0000_0001);
      sb_en      = 1'b0;
      threshold  = 32'hFFFF_FFFF;
      enable     = 1'b1;
      mask_ready = 1'b1;
      repeat (65600) tick();
      check("sat.valid", 32'(mask_valid), 32'd1);
      check_counts("sat", 16'hFFFF, 16'hFFFF);
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
      check_counts("clear", '0, '0);
      enable = 1'b0;
      tick();
      check_counts("clear.next", 16'd1, 16'd1);
      tick();
      sb_en = 1'b1;

      // Asynchronous reset during a stall discards the pending bit.
      restart(32'h0000_0001);
      threshold  = 32'hC000_0000;
      enable     = 1'b1;
      mask_ready = 1'b1;
      push(32'h8020_0003, 1'b1);
      tick();
      tick();
      mask_ready = 1'b0;
      check("async.pre_valid", 32'(mask_valid), 32'd1);
      check_counts("async.pre", 16'd1, 16'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async.valid", 32'(mask_valid), 32'd0);
      check("async.rnd", mask_rnd, 32'd0);
      check("async.drop", 32'(mask_drop), 32'd0);
      check_counts("async", '0, '0);
      enable = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      check("sb.leftover", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
